// File: rtl/riscv_pkg.sv
// RISC-V shared definitions: opcodes, immediate classes.
// Used by the decode-stage immediate generator.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT,
    IMM_ZIMM
  } imm_class_t;

  function automatic bit xlen_ok(input int x);
    return (x == 32) || (x == 64);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder.
// instr -> sign/zero-extended imm, class, illegal.
module imm_decode_comb
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_class_t      itype,
  output logic            illegal
);

  localparam bit RV64 = xlen_ok(XLEN) && (XLEN == 64);

  logic [6:0] op;
  logic [2:0] f3;
  logic       sh_f3;
  logic       sh64;
  logic       sh_ok;

  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign sh_f3 = (f3 == 3'b001) || (f3 == 3'b101);
  assign sh64  = RV64 && (op == OP_IMM);

  // 6-bit shamt frees instr[25], so only funct6 is checked
  assign sh_ok = sh64
    ? (instr[31:26] == 6'b000000) ||
      (instr[31:26] == 6'b010000)
    : (instr[31:25] == 7'b0000000) ||
      (instr[31:25] == 7'b0100000);

  function automatic logic [XLEN-1:0] sext(
    input logic [31:0] v
  );
    return XLEN'(signed'(v));
  endfunction

  // classify opcode and build the immediate
  always_comb begin
    imm     = '0;
    itype   = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_JALR): begin
        itype = IMM_I;
        imm   = sext({{20{instr[31]}}, instr[31:20]});
      end
      (op == OP_IMM),
      (op == OP_IMM32 && RV64): begin
        if (op == OP_IMM32 && f3 != 3'b000 && !sh_f3) begin
          illegal = 1'b1;
        end else if (!sh_f3) begin
          itype = IMM_I;
          imm   = sext({{20{instr[31]}}, instr[31:20]});
        end else if (!sh_ok) begin
          illegal = 1'b1;
        end else begin
          itype = IMM_SHAMT;
          imm   = sh64 ? XLEN'(instr[25:20])
                       : XLEN'(instr[24:20]);
        end
      end
      (op == OP_SYSTEM): begin
        if (f3 <= 3'b100) begin
          itype = IMM_I;
          imm   = sext({{20{instr[31]}}, instr[31:20]});
        end else begin
          itype = IMM_ZIMM;
          imm   = XLEN'(instr[19:15]);
        end
      end
      (op == OP_STORE): begin
        itype = IMM_S;
        imm   = sext({{20{instr[31]}},
                      instr[31:25], instr[11:7]});
      end
      (op == OP_BRANCH): begin
        itype = IMM_B;
        imm   = sext({{19{instr[31]}}, instr[31],
                      instr[7], instr[30:25],
                      instr[11:8], 1'b0});
      end
      (op == OP_LUI),
      (op == OP_AUIPC): begin
        itype = IMM_U;
        imm   = sext({instr[31:12], 12'b0});
      end
      (op == OP_JAL): begin
        itype = IMM_J;
        imm   = sext({{11{instr[31]}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0});
      end
      (op == OP_OP),
      (op == OP_OP32 && RV64): begin
        itype = IMM_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and
// register read, with optional 2-entry skid and flush.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_itype,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_class_t      itype;
    logic            illegal;
  } ent_t;

  ent_t            in_e;
  ent_t            m_q;
  ent_t            s_q;
  logic            m_v;
  logic            s_v;
  logic            main_free;
  logic            in_fire;
  logic [XLEN-1:0] d_imm;
  imm_class_t      d_it;
  logic            d_ill;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_dec (
    .instr  (in_instr),
    .imm    (d_imm),
    .itype  (d_it),
    .illegal(d_ill)
  );

  assign in_e = '{pc:      in_pc,
                  instr:   in_instr,
                  imm:     d_imm,
                  itype:   d_it,
                  illegal: d_ill};

  assign main_free = !m_v || out_ready;
  assign in_fire   = in_valid && in_ready;

  // main register: refill from skid first, else input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0;
      m_q <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
    end else if (main_free) begin
      if (s_v) begin
        m_v <= 1'b1;
        m_q <= s_q;
      end else begin
        m_v <= in_fire;
        if (in_fire) m_q <= in_e;
      end
    end
  end

  if (SKID_EN) begin : g_skid
    logic rdy_q;
    logic s_nxt;

    assign s_nxt = !flush && !main_free &&
                   (s_v || in_fire);
    assign in_ready = rdy_q;

    // skid catches the entry in flight when out stalls
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_v   <= 1'b0;
        s_q   <= '0;
        rdy_q <= 1'b0;
      end else begin
        s_v   <= s_nxt;
        rdy_q <= !s_nxt;
        if (in_fire && !main_free) s_q <= in_e;
      end
    end
  end else begin : g_pipe
    assign s_v      = 1'b0;
    assign s_q      = '0;
    assign in_ready = main_free;
  end

  assign out_valid   = m_v;
  assign out_instr   = m_q.instr;
  assign out_pc      = m_q.pc;
  assign out_imm     = m_q.imm;
  assign out_itype   = m_q.itype;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three instances
// (RV32 skid, RV32 no-skid, RV64 skid) behind a selector.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  int          sel;

  logic        a_iv, a_ir, a_ov, a_ill;
  logic [31:0] a_instr, a_pc, a_imm;
  logic [2:0]  a_it;
  logic        b_iv, b_ir, b_ov, b_ill;
  logic [31:0] b_instr, b_pc, b_imm;
  logic [2:0]  b_it;
  logic        c_iv, c_ir, c_ov, c_ill;
  logic [31:0] c_instr;
  logic [63:0] c_pc, c_imm;
  logic [2:0]  c_it;

  assign a_iv = in_valid && (sel == 0);
  assign b_iv = in_valid && (sel == 1);
  assign c_iv = in_valid && (sel == 2);

  imm_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc),
    .out_imm(a_imm), .out_itype(a_it),
    .out_illegal(a_ill));

  imm_decode_stage #(.XLEN(32), .SKID_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc),
    .out_imm(b_imm), .out_itype(b_it),
    .out_illegal(b_ill));

  imm_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(c_iv), .in_ready(c_ir),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(c_ov), .out_ready(out_ready),
    .out_instr(c_instr), .out_pc(c_pc),
    .out_imm(c_imm), .out_itype(c_it),
    .out_illegal(c_ill));

  logic        o_rdy, ov, o_ill;
  logic [31:0] o_instr;
  logic [63:0] o_pc, o_imm;
  logic [2:0]  o_it;

  // observed view of the selected instance
  always_comb begin
    o_rdy = a_ir; ov = a_ov; o_ill = a_ill;
    o_instr = a_instr; o_it = a_it;
    o_pc = {32'b0, a_pc}; o_imm = {32'b0, a_imm};
    if (sel == 1) begin
      o_rdy = b_ir; ov = b_ov; o_ill = b_ill;
      o_instr = b_instr; o_it = b_it;
      o_pc = {32'b0, b_pc}; o_imm = {32'b0, b_imm};
    end else if (sel == 2) begin
      o_rdy = c_ir; ov = c_ov; o_ill = c_ill;
      o_instr = c_instr; o_it = c_it;
      o_pc = c_pc; o_imm = c_imm;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  function automatic int xl_of(input int s);
    return (s == 2) ? 64 : 32;
  endfunction

  function automatic longint sx(input longint x, input int b);
    longint m;
    m = longint'(1) << b;
    x = x & (m - 1);
    return (x >= (m >> 1)) ? x - m : x;
  endfunction

  // reference decode from the ISA field layouts
  function automatic void ref_dec(
    input  logic [31:0] w, input int xl,
    output logic [63:0] imm, output logic [2:0] it,
    output logic ill);
    longint u, v, f7, f6;
    int op, f3;
    bit sh;
    u  = longint'(w);
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = (u >> 25) & 127;
    f6 = (u >> 26) & 63;
    sh = (f3 == 1) || (f3 == 5);
    v = 0; it = 0; ill = 0;
    case (op)
      'h03, 'h67: begin it = 1; v = sx(u >> 20, 12); end
      'h13: begin
        if (!sh) begin it = 1; v = sx(u >> 20, 12); end
        else if (xl == 64) begin
          if (f6 == 0 || f6 == 16) begin
            it = 6; v = (u >> 20) & 63;
          end else ill = 1;
        end else if (f7 == 0 || f7 == 32) begin
          it = 6; v = (u >> 20) & 31;
        end else ill = 1;
      end
      'h1b: begin
        if (xl != 64) ill = 1;
        else if (f3 == 0) begin it = 1; v = sx(u >> 20, 12); end
        else if (sh && (f7 == 0 || f7 == 32)) begin
          it = 6; v = (u >> 20) & 31;
        end else ill = 1;
      end
      'h73: begin
        if (f3 <= 4) begin it = 1; v = sx(u >> 20, 12); end
        else begin it = 7; v = (u >> 15) & 31; end
      end
      'h23: begin
        it = 2;
        v = sx(f7 * 32 + ((u >> 7) & 31), 12);
      end
      'h63: begin
        it = 3;
        v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
             + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
      end
      'h37, 'h17: begin it = 4; v = sx(u >> 12, 20) * 4096; end
      'h6f: begin
        it = 5;
        v = sx(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
             + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
      end
      'h33: ;
      'h3b: if (xl != 64) ill = 1;
      default: ill = 1;
    endcase
    if (ill) begin it = 0; v = 0; end
    imm = 64'(v);
    if (xl == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] pool [14] = '{7'h03, 7'h13, 7'h1b, 7'h17,
      7'h23, 7'h33, 7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f,
      7'h73, 7'h7f, 7'h0b};
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 7) != 0)
      w[6:0] = pool[$urandom_range(0, 13)];
    if ($urandom_range(0, 1) != 0)
      w[31:26] = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'd16;
    return w;
  endfunction

  function automatic logic [63:0] rand_pc(input int s);
    logic [63:0] p;
    p = {$urandom(), $urandom()};
    if (s != 2) p[63:32] = 32'b0;
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_instr = '0; in_pc = '0; sel = 0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_tot++;
      if (ov !== 1'b0 || o_imm !== 64'd0 || o_it !== 3'd0 ||
          o_ill !== 1'b0 || o_instr !== 32'd0 || o_pc !== 64'd0)
        $display("FAIL reset_out sel=%0d: got v=%b imm=%h it=%0d ill=%b want 0",
                 s, ov, o_imm, o_it, o_ill);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_tot++;
      if (o_rdy !== 1'b1)
        $display("FAIL reset_ready sel=%0d: got %b want 1", s, o_rdy);
      else n_pass++;
    end
    sel = 0;
  endtask

  typedef struct {
    logic [31:0] w;
    int          s;
    logic [63:0] imm;
    logic [2:0]  it;
    logic        ill;
  } vec_t;

  task automatic test_vectors();
    vec_t v [14] = '{
      '{32'hFFF00093, 0, 64'hFFFFFFFF, 3'd1, 1'b0},
      '{32'hFE112E23, 0, 64'hFFFFFFFC, 3'd2, 1'b0},
      '{32'h123452B7, 0, 64'h12345000, 3'd4, 1'b0},
      '{32'hFFDFF06F, 0, 64'hFFFFFFFC, 3'd5, 1'b0},
      '{32'h4030D093, 0, 64'h3,        3'd6, 1'b0},
      '{32'h0250D093, 0, 64'h0,        3'd0, 1'b1},
      '{32'h0250D093, 2, 64'h25,       3'd6, 1'b0},
      '{32'h0002D073, 0, 64'h5,        3'd7, 1'b0},
      '{32'h0000007F, 0, 64'h0,        3'd0, 1'b1},
      '{32'hFFF00091, 0, 64'h0,        3'd0, 1'b1},
      '{32'hFFF00093, 2, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
      '{32'hFFF00093, 1, 64'hFFFFFFFF, 3'd1, 1'b0},
      '{32'h00000033, 0, 64'h0,        3'd0, 1'b0},
      '{32'h0000003B, 0, 64'h0,        3'd0, 1'b1}};
    logic [63:0] pc;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sel = v[i].s; out_ready = 1'b1;
      pc = rand_pc(v[i].s);
      in_valid = 1'b1; in_instr = v[i].w; in_pc = pc;
      #1;
      n_tot++;
      if (o_rdy !== 1'b1)
        $display("FAIL vec%0d_ready: got %b want 1", i, o_rdy);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_tot++;
      if (ov !== 1'b1 || o_imm !== v[i].imm || o_it !== v[i].it ||
          o_ill !== v[i].ill || o_instr !== v[i].w || o_pc !== pc)
        $display("FAIL vec%0d %h: got v=%b imm=%h it=%0d ill=%b want v=1 imm=%h it=%0d ill=%b",
                 i, v[i].w, ov, o_imm, o_it, o_ill,
                 v[i].imm, v[i].it, v[i].ill);
      else n_pass++;
      @(negedge clk);
      #1;
      n_tot++;
      if (ov !== 1'b0)
        $display("FAIL vec%0d_drain: got v=%b want 0", i, ov);
      else n_pass++;
    end
  endtask

  task automatic test_decode_random();
    logic [31:0] w;
    logic [63:0] e_imm;
    logic [2:0]  e_it;
    logic        e_ill;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      sel = (i % 3);
      w = rand_instr();
      in_valid = 1'b1; in_instr = w; in_pc = rand_pc(sel);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      ref_dec(w, xl_of(sel), e_imm, e_it, e_ill);
      n_tot++;
      if (ov !== 1'b1 || o_imm !== e_imm || o_it !== e_it ||
          o_ill !== e_ill)
        $display("FAIL rand_dec sel=%0d %h: got v=%b imm=%h it=%0d ill=%b want imm=%h it=%0d ill=%b",
                 sel, w, ov, o_imm, o_it, o_ill, e_imm, e_it, e_ill);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  // mode 0: continuous input, out stalled cycles 3-5
  // mode 1: random valid and ready
  task automatic test_stream(input int n, input int mode,
                             input int s);
    logic [31:0] qi [$];
    logic [63:0] qp [$];
    logic [63:0] e_imm;
    logic [2:0]  e_it;
    logic        e_ill, e_rdy, acc;
    int sent = 0;
    int cyc  = 0;
    acc = 1'b0;
    sel = s;
    in_valid = 1'b0;
    while (sent < n || qi.size() > 0) begin
      if (cyc >= 400) begin
        n_tot++;
        $display("FAIL stream_budget sel=%0d: got %0d left want 0",
                 s, qi.size());
        break;
      end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (sent < n && !in_valid &&
          (mode == 0 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_instr = rand_instr();
        in_pc = rand_pc(s);
      end
      out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 5)
                              : ($urandom_range(0, 2) != 0);
      #1;
      n_tot++;
      if (ov !== (qi.size() > 0))
        $display("FAIL stream_valid sel=%0d cyc=%0d: got %b want %b",
                 s, cyc, ov, qi.size() > 0);
      else n_pass++;
      e_rdy = (s == 1) ? (qi.size() == 0 || out_ready)
                       : (qi.size() < 2);
      n_tot++;
      if (o_rdy !== e_rdy)
        $display("FAIL stream_ready sel=%0d cyc=%0d: got %b want %b",
                 s, cyc, o_rdy, e_rdy);
      else n_pass++;
      if (ov === 1'b1 && qi.size() > 0) begin
        ref_dec(qi[0], xl_of(s), e_imm, e_it, e_ill);
        n_tot++;
        if (o_instr !== qi[0] || o_pc !== qp[0] ||
            o_imm !== e_imm || o_it !== e_it || o_ill !== e_ill)
          $display("FAIL stream_data sel=%0d cyc=%0d: got %h/%h/%h want %h/%h/%h",
                   s, cyc, o_instr, o_pc, o_imm,
                   qi[0], qp[0], e_imm);
        else n_pass++;
      end
      if (ov === 1'b1 && out_ready && qi.size() > 0) begin
        void'(qi.pop_front());
        void'(qp.pop_front());
      end
      acc = in_valid && (o_rdy === 1'b1);
      if (acc) begin
        qi.push_back(in_instr);
        qp.push_back(in_pc);
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flush();
    sel = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h100;
    @(negedge clk);
    in_instr = 32'h00200113; in_pc = 64'h104;
    #1;
    n_tot++;
    if (o_rdy !== 1'b1)
      $display("FAIL flush_fill_ready: got %b want 1", o_rdy);
    else n_pass++;
    @(negedge clk);
    in_instr = 32'h00300193; in_pc = 64'h108; flush = 1'b1;
    #1;
    n_tot++;
    if (o_rdy !== 1'b0 || ov !== 1'b1 || o_instr !== 32'h00100093)
      $display("FAIL flush_full: got rdy=%b v=%b i=%h want 0/1/00100093",
               o_rdy, ov, o_instr);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_tot++;
    if (ov !== 1'b0)
      $display("FAIL flush_clear: got v=%b want 0", ov);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 64'h10C;
    #1;
    n_tot++;
    if (o_rdy !== 1'b1)
      $display("FAIL flush_ready_after: got %b want 1", o_rdy);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tot++;
    if (ov !== 1'b1 || o_instr !== 32'h00400213 || o_imm !== 64'd4)
      $display("FAIL flush_next: got v=%b i=%h imm=%h want 1/00400213/4",
               ov, o_instr, o_imm);
    else n_pass++;
    @(negedge clk);
    #1;
    n_tot++;
    if (ov !== 1'b0)
      $display("FAIL flush_alone: got v=%b want 0", ov);
    else n_pass++;
    sel = 1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500293;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tot++;
    if (ov !== 1'b0)
      $display("FAIL flush_noskid: got v=%b want 0", ov);
    else n_pass++;
    out_ready = 1'b1;
    sel = 0;
  endtask

  task automatic test_async_reset();
    sel = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h200;
    @(negedge clk);
    in_instr = 32'h123452B7; in_pc = 64'h204;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tot++;
    if (ov !== 1'b0 || o_imm !== 64'd0 ||
        $isunknown({o_rdy, o_instr, o_pc, o_imm, o_it, o_ill}))
      $display("FAIL async_rst: got v=%b imm=%h want v=0 imm=0 no X",
               ov, o_imm);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tot++;
    if (o_rdy !== 1'b1 || ov !== 1'b0)
      $display("FAIL rst_resume_ready: got rdy=%b v=%b want 1/0",
               o_rdy, ov);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0002D073; in_pc = 64'h300;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tot++;
    if (ov !== 1'b1 || o_instr !== 32'h0002D073 ||
        o_imm !== 64'd5 || o_it !== 3'd7)
      $display("FAIL rst_resume_data: got v=%b i=%h imm=%h it=%0d want 1/0002D073/5/7",
               ov, o_instr, o_imm, o_it);
    else n_pass++;
    @(negedge clk);
    #1;
    n_tot++;
    if (ov !== 1'b0)
      $display("FAIL rst_resume_drain: got v=%b want 0", ov);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_decode_random();
    for (int s = 0; s < 3; s++) test_stream(8, 0, s);
    for (int s = 0; s < 3; s++) test_stream(40, 1, s);
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
